// File: rtl/cache_pkg.sv
// cache_pkg: default geometry, derived widths and way-entry type for the tag-only cache.
package cache_pkg;
  localparam int DEF_CACHE_SIZE = 8192;
  localparam int DEF_LINE_SIZE = 32;
  localparam int DEF_ASSOC = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int NUM_SETS = DEF_CACHE_SIZE / (DEF_LINE_SIZE * DEF_ASSOC);
  localparam int OFFSET_W = $clog2(DEF_LINE_SIZE);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W = DEF_ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int AGE_W = DEF_ASSOC > 1 ? $clog2(DEF_ASSOC) : 1;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [AGE_W-1:0] age;
  } way_t;
  function automatic int clog2_min1(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/cache_lru_update.sv
// cache_lru_update: promotes the accessed way to MRU and picks the miss victim for one set.
module cache_lru_update
  import cache_pkg::*;
#(
  parameter int ASSOC = DEF_ASSOC,
  localparam int WAY_W = clog2_min1(ASSOC)
) (
  input  logic [ASSOC-1:0][WAY_W-1:0] age,
  input  logic [ASSOC-1:0]            valid,
  input  logic [WAY_W-1:0]            way,
  output logic [ASSOC-1:0][WAY_W-1:0] new_age,
  output logic [WAY_W-1:0]            victim
);
  always_comb begin
    victim = '0;
    new_age = age;
    for (int i = ASSOC - 1; i >= 0; i--)
      if (age[i] == WAY_W'(ASSOC - 1)) victim = WAY_W'(i);
    // an invalid way always beats the LRU way; lowest index wins
    for (int i = ASSOC - 1; i >= 0; i--)
      if (!valid[i]) victim = WAY_W'(i);
    for (int i = 0; i < ASSOC; i++)
      new_age[i] = WAY_W'(i) == way ? '0 : age[i] < age[way] ? age[i] + 1'b1 : age[i];
  end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: tag-only set-associative LRU cache classifying each access as hit or miss.
module cache_controller
  import cache_pkg::*;
#(
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int ASSOCIATIVITY = DEF_ASSOC,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_en,
  output logic [31:0]           misses,
  output logic [31:0]           hits,
  output logic                  hit_flag
);
  localparam int n_sets = CACHE_SIZE / (LINE_SIZE * ASSOCIATIVITY);
  localparam int off_w = $clog2(LINE_SIZE);
  localparam int idx_w = clog2_min1(n_sets);
  localparam int tag_w = ADDR_WIDTH - off_w - (n_sets > 1 ? $clog2(n_sets) : 0);
  localparam int way_w = clog2_min1(ASSOCIATIVITY);
  logic [ASSOCIATIVITY-1:0] valid [n_sets];
  logic [ASSOCIATIVITY-1:0][tag_w-1:0] tags [n_sets];
  logic [ASSOCIATIVITY-1:0][way_w-1:0] ages [n_sets];
  logic [ASSOCIATIVITY-1:0][way_w-1:0] new_age;
  logic [idx_w-1:0] idx;
  logic [tag_w-1:0] tag;
  logic [way_w-1:0] hit_way, victim, acc_way;
  logic hit;
  logic unused_offset;
  assign unused_offset = ^addr[off_w-1:0];
  assign tag = addr[ADDR_WIDTH-1:ADDR_WIDTH-tag_w];
  generate
    if (n_sets > 1) begin : g_idx
      assign idx = addr[off_w+idx_w-1:off_w];
    end else begin : g_noidx
      assign idx = '0;
    end
  endgenerate
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int i = 0; i < ASSOCIATIVITY; i++)
      if (valid[idx][i] && tags[idx][i] == tag) begin
        hit = 1'b1;
        hit_way = way_w'(i);
      end
  end
  assign acc_way = hit ? hit_way : victim;
  cache_lru_update #(.ASSOC(ASSOCIATIVITY)) u_lru (
    .age(ages[idx]),
    .valid(valid[idx]),
    .way(acc_way),
    .new_age(new_age),
    .victim(victim)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < n_sets; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) ages[s][w] <= way_w'(w);
      end
      hits <= '0;
      misses <= '0;
      hit_flag <= 1'b0;
    end else if (rd_en) begin
      valid[idx][acc_way] <= 1'b1;
      tags[idx][acc_way] <= tag;
      ages[idx] <= new_age;
      hits <= hits + {31'd0, hit};
      misses <= misses + {31'd0, !hit};
      hit_flag <= hit;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and random trace checks against a recency-list LRU model.
module tb_cache_controller;
  logic clk, rst, rd_en, hit_flag;
  logic [31:0] addr, hits, misses;
  int errors = 0, checks = 0;
  int unsigned mh = 0, mm = 0;
  logic [20:0] lru_q [64][$];

  cache_controller dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en),
    .misses(misses), .hits(hits), .hit_flag(hit_flag)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model_access(input logic [31:0] a, output bit h);
    int s;
    int found;
    logic [20:0] t;
    s = int'(a[10:5]);
    t = a[31:11];
    found = -1;
    for (int i = 0; i < lru_q[s].size(); i++)
      if (lru_q[s][i] == t && found < 0) found = i;
    h = found >= 0;
    if (h) lru_q[s].delete(found);
    else if (lru_q[s].size() == 4) void'(lru_q[s].pop_back());
    lru_q[s].push_front(t);
    if (h) mh++; else mm++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1; rd_en = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int s = 0; s < 64; s++) lru_q[s].delete();
    mh = 0; mm = 0;
  endtask

  task automatic acc(input logic [31:0] a);
    bit h;
    @(negedge clk);
    addr = a; rd_en = 1;
    @(posedge clk); #1;
    rd_en = 0;
    model_access(a, h);
    checks += 3;
    if (hit_flag !== h) begin errors++; $display("FAIL hit_flag addr=%h got=%b exp=%b", a, hit_flag, h); end
    if (hits !== mh) begin errors++; $display("FAIL hits addr=%h got=%0d exp=%0d", a, hits, mh); end
    if (misses !== mm) begin errors++; $display("FAIL misses addr=%h got=%0d exp=%0d", a, misses, mm); end
  endtask

  task automatic expect_totals(input string name, input int unsigned eh, input int unsigned em);
    checks += 2;
    if (hits !== eh) begin errors++; $display("FAIL %s hits got=%0d exp=%0d", name, hits, eh); end
    if (misses !== em) begin errors++; $display("FAIL %s misses got=%0d exp=%0d", name, misses, em); end
  endtask

  task automatic test_reset();
    reset_dut();
    expect_totals("reset", 0, 0);
    checks++;
    if (hit_flag !== 1'b0) begin errors++; $display("FAIL reset hit_flag got=%b exp=0", hit_flag); end
  endtask

  task automatic test_same_addr();
    logic [2:0] seq;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      acc(32'h0);
      seq[i] = hit_flag;
    end
    checks++;
    if (seq !== 3'b110) begin errors++; $display("FAIL same_addr flags got=%b exp=110", seq); end
    expect_totals("same_addr", 2, 1);
  endtask

  task automatic test_line();
    reset_dut();
    acc(32'h0); acc(32'h4); acc(32'h1F); acc(32'h20);
    expect_totals("line", 2, 2);
  endtask

  task automatic test_lru();
    logic [31:0] seq [8] = '{32'h0, 32'h800, 32'h1000, 32'h1800, 32'h0, 32'h2000, 32'h800, 32'h0};
    logic [7:0] flags;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      acc(seq[i]);
      flags[i] = hit_flag;
    end
    checks++;
    if (flags !== 8'b1001_0000) begin errors++; $display("FAIL lru flags got=%b exp=10010000", flags); end
    expect_totals("lru", 2, 6);
  endtask

  task automatic test_hold();
    logic f;
    f = hit_flag;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      addr = $urandom; rd_en = 0;
      @(posedge clk); #1;
      expect_totals("hold", mh, mm);
      checks++;
      if (hit_flag !== f) begin errors++; $display("FAIL hold hit_flag got=%b exp=%b", hit_flag, f); end
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    acc(32'h0); acc(32'h0); acc(32'h0);
    expect_totals("pre_reset", 2, 1);
    reset_dut();
    expect_totals("mid_reset", 0, 0);
    checks++;
    if (hit_flag !== 1'b0) begin errors++; $display("FAIL mid_reset hit_flag got=%b exp=0", hit_flag); end
    acc(32'h0);
    expect_totals("after_reset", 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    reset_dut();
    for (int i = 0; i < 10000; i++) begin
      a = ($urandom_range(0, 7) << 11) | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      acc(a);
    end
    checks++;
    if (hits + misses !== 32'd10000) begin errors++; $display("FAIL random total got=%0d exp=10000", hits + misses); end
  endtask

  initial begin
    rst = 1; rd_en = 0; addr = 0;
    test_reset();
    test_same_addr();
    test_line();
    test_lru();
    test_hold();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
